// File: rtl/ps2_mmio_port.sv
// Memory-mapped PS2 keyboard port: buffers scan bytes in a FIFO and serves
// DATA/STATUS/CTRL loads and stores from the MEM stage, with a level interrupt.
module ps2_mmio_port #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  output logic        irq
);

  localparam logic [1:0]  OFF_DATA   = 2'd0;
  localparam logic [1:0]  OFF_STATUS = 2'd1;
  localparam logic [1:0]  OFF_CTRL   = 2'd2;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          irq_en;

  logic          rd_req, wr_req;
  logic          empty, full;
  logic          pop, push, clear, ovf_set, ovf_clr;
  logic [4:0]    count_ext;
  logic [31:0]   read_value;
  logic          unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:3]};

  assign rd_req  = sel & mem_read;
  assign wr_req  = sel & mem_write;
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte.
  assign pop     = rd_req & (addr[3:2] == OFF_DATA) & ~empty;
  assign push    = key_valid & (~full | pop);
  assign clear   = wr_req & (addr[3:2] == OFF_CTRL) & wdata[0];
  assign ovf_set = key_valid & full & ~pop;
  assign ovf_clr = wr_req & (addr[3:2] == OFF_CTRL) & wdata[1];

  assign count_ext = 5'(count);

  always_comb begin
    read_value = 32'h0;
    case (addr[3:2])
      OFF_DATA:   read_value = empty ? 32'h0 : {24'h0, mem[rd_ptr]};
      OFF_STATUS: read_value = {20'h0, overflow, irq_en, full, count_ext, 3'b000, ~empty};
      OFF_CTRL:   read_value = {29'h0, irq_en, 2'b00};
      default:    read_value = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= key_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      rdata    <= 32'h0;
      irq      <= 1'b0;
    end else begin
      if (rd_req) begin
        rdata <= read_value;
      end
      if (wr_req && addr[3:2] == OFF_CTRL) begin
        irq_en <= wdata[2];
      end
      // Clear of overflow wins over a same-cycle dropped byte.
      if (ovf_clr) begin
        overflow <= 1'b0;
      end else if (ovf_set) begin
        overflow <= 1'b1;
      end
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
      irq <= irq_en & ~empty;
    end
  end

endmodule
